gamepad_pmod_tx: RTL and testbench

// - Transmit end of the Gamepad Pmod serial link: serializes 1-2 controllers' button states onto pmod_clk/pmod_data, then commits with pmod_latch.
// - Drives the same three wires that gamepad_pmod_single samples. Used as a bench/demo stimulus source and as an on-chip controller emulator (e.g. scripted attract mode for the screensaver).

---
 rtl/gamepad_pkg.sv | 21 ++
 rtl/pmod_clk_div.sv | 18 +
 rtl/gamepad_pmod_tx.sv | 108 ++++++++++
 tb/tb_gamepad_pmod_tx.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/gamepad_pkg.sv
// gamepad_pkg: button bit map, pad width and FSM state encoding shared by the Gamepad Pmod link
package gamepad_pkg;
  localparam int PAD_BITS   = 12;
  localparam int BTN_B      = 11;
  localparam int BTN_Y      = 10;
  localparam int BTN_SELECT = 9;
  localparam int BTN_START  = 8;
  localparam int BTN_UP     = 7;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_A      = 3;
  localparam int BTN_X      = 2;
  localparam int BTN_L      = 1;
  localparam int BTN_R      = 0;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_GAP   = 2'd2;
  localparam state_t ST_LATCH = 2'd3;
endpackage

// File: rtl/pmod_clk_div.sv
// pmod_clk_div: half-period strobe for the Pmod serial clock, realigned to phase 0 on clr_i
module pmod_clk_div #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic stb_o
);
  localparam int CW = $clog2(HALF_PERIOD + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign stb_o = cnt_q == CW'(HALF_PERIOD - 1);
  assign cnt_d = (clr_i || stb_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/gamepad_pmod_tx.sv
// gamepad_pmod_tx: serializes 1-2 pads of button state onto pmod_clk/pmod_data, then pulses pmod_latch
module gamepad_pmod_tx
  import gamepad_pkg::*;
#(
  parameter int NUM_PADS     = 1,
  parameter int HALF_PERIOD  = 4,
  parameter int LATCH_CYCLES = 4,
  parameter int FRAME_CYCLES = 2048
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PAD_BITS-1:0] btn_p0,
  input  logic [PAD_BITS-1:0] btn_p1,
  input  logic                send_now,
  input  logic                auto_en,
  output logic                busy,
  output logic                frame_done,
  output logic                pmod_clk,
  output logic                pmod_data,
  output logic                pmod_latch
);
  localparam int NB = PAD_BITS * NUM_PADS;
  localparam int BW = $clog2(NB);
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam int AW = $clog2(FRAME_CYCLES);
  state_t state_q, state_d;
  logic [NB-1:0] shr_q, shr_d, word;
  logic [BW-1:0] bit_q, bit_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [AW-1:0] auto_q, auto_d;
  logic hi_q, hi_d, pend_q, pend_d;
  logic idle, tick, req, start, stb;
  generate
    if (NUM_PADS == 2) begin : g_two
      assign word = {btn_p1, btn_p0};
    end else begin : g_one
      logic unused_p1;
      assign word = btn_p0;
      assign unused_p1 = ^btn_p1;
    end
  endgenerate
  assign idle  = state_q == ST_IDLE;
  assign tick  = auto_en && auto_q == '0;
  assign req   = send_now || tick;
  assign start = idle && (req || pend_q);
  assign auto_d = !auto_en ? '0 : auto_q == AW'(FRAME_CYCLES - 1) ? '0 : auto_q + 1'b1;
  pmod_clk_div #(.HALF_PERIOD(HALF_PERIOD)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(start),
    .stb_o(stb)
  );
  always_comb begin
    state_d = state_q;
    shr_d   = shr_q;
    bit_d   = bit_q;
    lat_d   = lat_q;
    hi_d    = hi_q;
    pend_d  = idle ? 1'b0 : pend_q || req;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_SHIFT;
        shr_d   = word;
        bit_d   = BW'(NB - 1);
        hi_d    = 1'b0;
      end
      ST_SHIFT: if (stb) begin
        hi_d = !hi_q;
        // a bit ends on the falling half-edge; the next bit appears while pmod_clk is low
        if (hi_q && bit_q == '0) state_d = ST_GAP;
        else if (hi_q) begin
          bit_d = bit_q - 1'b1;
          shr_d = {shr_q[NB-2:0], 1'b0};
        end
      end
      ST_GAP: if (stb) begin
        state_d = ST_LATCH;
        lat_d   = LW'(LATCH_CYCLES - 1);
      end
      default: if (lat_q == '0) state_d = ST_IDLE;
        else lat_d = lat_q - 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shr_q   <= '0;
      bit_q   <= '0;
      lat_q   <= '0;
      auto_q  <= '0;
      hi_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shr_q   <= shr_d;
      bit_q   <= bit_d;
      lat_q   <= lat_d;
      auto_q  <= auto_d;
      hi_q    <= hi_d;
      pend_q  <= pend_d;
    end
  end
  assign busy       = !idle;
  assign frame_done = state_q == ST_LATCH && lat_q == '0;
  assign pmod_clk   = state_q == ST_SHIFT && hi_q;
  assign pmod_data  = state_q == ST_SHIFT && shr_q[NB-1];
  assign pmod_latch = state_q == ST_LATCH;
endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// tb_gamepad_pmod_tx: directed and randomized frames for 1-pad and 2-pad transmitters against a cycle-timeline model
module tb_gamepad_pmod_tx;
  import gamepad_pkg::*;
  localparam int H = 2;
  localparam int L = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [11:0] a_p0, a_p1, b_p0, b_p1;
  logic a_send, a_auto, b_send, b_auto;
  logic a_busy, a_done, a_clk, a_data, a_lat;
  logic b_busy, b_done, b_clk, b_data, b_lat;
  logic [23:0] w;
  int ntests = 0;
  int nfail = 0;
  gamepad_pmod_tx #(.NUM_PADS(1), .HALF_PERIOD(H), .LATCH_CYCLES(L), .FRAME_CYCLES(2048)) u_a (
    .clk(clk), .rst_n(rst_n), .btn_p0(a_p0), .btn_p1(a_p1), .send_now(a_send), .auto_en(a_auto),
    .busy(a_busy), .frame_done(a_done), .pmod_clk(a_clk), .pmod_data(a_data), .pmod_latch(a_lat)
  );
  gamepad_pmod_tx #(.NUM_PADS(2), .HALF_PERIOD(H), .LATCH_CYCLES(L), .FRAME_CYCLES(128)) u_b (
    .clk(clk), .rst_n(rst_n), .btn_p0(b_p0), .btn_p1(b_p1), .send_now(b_send), .auto_en(b_auto),
    .busy(b_busy), .frame_done(b_done), .pmod_clk(b_clk), .pmod_data(b_data), .pmod_latch(b_lat)
  );
  function automatic logic [4:0] obs(input bit sel);
    return sel ? {b_busy, b_done, b_clk, b_data, b_lat} : {a_busy, a_done, a_clk, a_data, a_lat};
  endfunction
  // expected {busy,frame_done,pmod_clk,pmod_data,pmod_latch} t cycles after the start edge
  function automatic logic [4:0] exp_at(input int t, input int n, input logic [23:0] wd);
    int f = n * 2 * H + H + L;
    if (t < n * 2 * H) return {1'b1, 1'b0, ((t % (2 * H)) >= H) ? 1'b1 : 1'b0, wd[n - 1 - t / (2 * H)], 1'b0};
    if (t < n * 2 * H + H) return 5'b10000;
    if (t < f) return {1'b1, (t == f - 1) ? 1'b1 : 1'b0, 3'b001};
    return 5'b00000;
  endfunction
  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic kick(input bit sel);
    @(posedge clk);
    #1;
    if (sel) b_send = 1'b1;
    else a_send = 1'b1;
    @(posedge clk);
    #1;
    a_send = 1'b0;
    b_send = 1'b0;
  endtask
  task automatic idle_chk(input bit sel, input int k, input string tag);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk($sformatf("%s i=%0d", tag, i), 24'(obs(sel)), 24'h0);
    end
  endtask
  // mode 1: change a_p0 and pulse a_send three times mid-frame; mode 2: drop b_auto mid-frame
  task automatic check_frame(input bit sel, input logic [23:0] wd, input int ncyc, input int mode, input string tag);
    int n = sel ? 24 : 12;
    int f = n * 2 * H + H + L;
    int lim = ncyc < 0 ? f : ncyc;
    int rises = 0;
    logic prev = 1'b0;
    logic [23:0] rx = '0;
    logic [4:0] o;
    for (int t = 0; t < lim; t++) begin
      @(negedge clk);
      o = obs(sel);
      chk($sformatf("%s t=%0d", tag, t), 24'(o), 24'(exp_at(t, n, wd)));
      if (o[2] && !prev) begin
        rises++;
        rx = {rx[22:0], o[1]};
      end
      prev = o[2];
      if (mode == 1) begin
        if (t == 10) a_p0 = 12'h800;
        a_send = (t == 10 || t == 20 || t == 30);
      end
      if (mode == 2 && t == 50) b_auto = 1'b0;
    end
    if (lim == f) begin
      chk({tag, " rises"}, 24'(rises), 24'(n));
      chk({tag, " rx"}, rx, wd);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    {a_p0, a_p1, b_p0, b_p1} = '0;
    {a_send, a_auto, b_send, b_auto} = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset a", 24'(obs(0)), 24'h0);
    chk("reset b", 24'(obs(1)), 24'h0);
    a_p0 = 12'hA5C;
    kick(0);
    check_frame(0, 24'hA5C, -1, 0, "a5c");
    idle_chk(0, 3, "a5c idle");
    a_p0 = 12'(1 << BTN_START);
    kick(0);
    check_frame(0, {12'h0, a_p0}, -1, 0, "start");
    a_p0 = 12'h0;
    kick(0);
    check_frame(0, 24'h0, -1, 0, "zero");
    for (int k = 0; k < 3; k++) begin
      a_p0 = 12'($urandom);
      a_p1 = 12'($urandom);
      kick(0);
      check_frame(0, {12'h0, a_p0}, -1, 0, $sformatf("rand1 %0d", k));
    end
    b_p1 = 12'hFFF;
    b_p0 = 12'h000;
    kick(1);
    check_frame(1, 24'hFFF000, -1, 0, "two pads");
    idle_chk(1, 3, "two idle");
    for (int k = 0; k < 2; k++) begin
      b_p0 = 12'($urandom);
      b_p1 = 12'($urandom);
      kick(1);
      check_frame(1, {b_p1, b_p0}, -1, 0, $sformatf("rand2 %0d", k));
    end
    a_p0 = 12'h001;
    kick(0);
    check_frame(0, 24'h001, -1, 1, "mid change");
    idle_chk(0, 1, "pend gap");
    check_frame(0, 24'h800, -1, 0, "pend frame");
    idle_chk(0, 60, "no extra");
    b_p0 = 12'($urandom);
    b_p1 = 12'($urandom);
    w = {b_p1, b_p0};
    @(posedge clk);
    #1 b_auto = 1'b1;
    b_send = 1'b1;
    @(posedge clk);
    #1 b_send = 1'b0;
    check_frame(1, w, -1, 0, "auto1");
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      chk($sformatf("auto gap i=%0d", i), 24'(obs(1)), 24'h0);
      if (i == 5) b_p0 = ~b_p0;
    end
    check_frame(1, {b_p1, b_p0}, -1, 2, "auto2");
    idle_chk(1, 200, "auto off");
    a_p0 = 12'($urandom);
    kick(0);
    check_frame(0, {12'h0, a_p0}, 22, 0, "pre rst");
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst mid a", 24'(obs(0)), 24'h0);
    chk("rst mid b", 24'(obs(1)), 24'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    a_p0 = 12'($urandom);
    kick(0);
    check_frame(0, {12'h0, a_p0}, -1, 0, "post rst");
    idle_chk(0, 3, "post idle");
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
